// File: rtl/inst_mem.sv
// Instruction memory with a byte-serial program loader and a registered fetch port.
// The optional INST_MEM_PARITY_EN macro adds per-word even parity and a parity_err output.
module inst_mem #(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic [31:0]       addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              addr_err,
`ifdef INST_MEM_PARITY_EN
  output logic              parity_err,
`endif
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [CNT_W-1:0]     byte_cnt;
  logic [DATA_W-1:0]    word_buf;

  logic [DATA_W-1:0]    mem [DEPTH];
`ifdef INST_MEM_PARITY_EN
  logic                 par_mem [DEPTH];
`endif

  logic [DATA_W-1:0]     lane_word_c;
  logic                  load_byte_c;
  logic                  word_end_c;
  logic                  wr_en_c;
  logic [DEPTH_LOG2-1:0] rd_idx_c;
  logic                  bad_addr_c;
  logic                  fetch_ok_c;

  // Byte-lane merge, word-completion and write-enable decode for the loader
  always_comb begin
    lane_word_c = word_buf;
    lane_word_c[8*byte_cnt +: 8] = ld_byte;
    load_byte_c = (state == LOAD) && ld_valid;
    word_end_c  = load_byte_c && (ld_last || (byte_cnt == LAST_LANE));
    // Pointer MSB set means the memory is full; further writes are dropped
    wr_en_c     = word_end_c && !ptr[DEPTH_LOG2];
    rd_idx_c    = addr[DEPTH_LOG2+1:2];
    bad_addr_c  = (addr[1:0] != 2'b00) || (|addr[31:DEPTH_LOG2+2]);
    // Fetches are refused while loading and in the cycle a load is started
    fetch_ok_c  = (state == IDLE) && !ld_start && fetch_en;
  end

  // Memory array write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[ptr[DEPTH_LOG2-1:0]] <= lane_word_c;
`ifdef INST_MEM_PARITY_EN
      par_mem[ptr[DEPTH_LOG2-1:0]] <= ^lane_word_c;
`endif
    end
  end

  // Loader FSM: byte assembly, word pointer, overflow and completion flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      byte_cnt    <= '0;
      word_buf    <= '0;
      ld_busy     <= 1'b0;
      ld_done     <= 1'b0;
      ld_overflow <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start) begin
            state       <= LOAD;
            ld_busy     <= 1'b1;
            ptr         <= '0;
            byte_cnt    <= '0;
            word_buf    <= '0;
            ld_overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (load_byte_c) begin
            if (word_end_c) begin
              // Clearing the buffer leaves unfilled lanes of the next partial word zero
              word_buf <= '0;
              byte_cnt <= '0;
              if (ptr[DEPTH_LOG2]) ld_overflow <= 1'b1;
              else                 ptr <= ptr + PTR_W'(1);
            end else begin
              word_buf <= lane_word_c;
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
            if (ld_last) begin
              state   <= IDLE;
              ld_busy <= 1'b0;
              ld_done <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ld_busy <= 1'b0;
        end
      endcase
    end
  end

  // Registered fetch port with stall hold and address checking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst       <= '0;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
`ifdef INST_MEM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (!stall) begin
      inst       <= '0;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
`ifdef INST_MEM_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (fetch_ok_c) begin
        inst_valid <= 1'b1;
        if (bad_addr_c) begin
          addr_err <= 1'b1;
        end else begin
`ifdef INST_MEM_PARITY_EN
          if (^{mem[rd_idx_c], par_mem[rd_idx_c]}) parity_err <= 1'b1;
          else                                      inst <= mem[rd_idx_c];
`else
          inst <= mem[rd_idx_c];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_mem.sv
// Directed self-checking bench for inst_mem (default parameters).
module tb_inst_mem;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        stall;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        inst_valid;
  logic        addr_err;
`ifdef INST_MEM_PARITY_EN
  logic        parity_err;
`endif
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_overflow;

  int n_assert = 0;
  int n_fail   = 0;

  inst_mem dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .stall       (stall),
    .addr        (addr),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .addr_err    (addr_err),
`ifdef INST_MEM_PARITY_EN
    .parity_err  (parity_err),
`endif
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_byte     (ld_byte),
    .ld_last     (ld_last),
    .ld_busy     (ld_busy),
    .ld_done     (ld_done),
    .ld_overflow (ld_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_en = 1'b1;
    addr     = a;
    step();
  endtask

  initial begin
    logic [7:0]  prog [8];
    logic [31:0] word;
    prog = '{8'h40, 8'h0E, 8'h10, 8'h00, 8'h26, 8'h38, 8'h00, 8'h28};

    rst_n = 1'b0; fetch_en = 1'b0; stall = 1'b0; addr = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    #1;
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_err", 32'(addr_err), 32'h0);
    chk("rst_busy", 32'(ld_busy), 32'h0);
    chk("rst_done", 32'(ld_done), 32'h0);
    chk("rst_ovf", 32'(ld_overflow), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Two-word program load
    ld_start = 1'b1; step(); ld_start = 1'b0;
    chk("load_busy", 32'(ld_busy), 32'h1);
    for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7);
    chk("load_idle", 32'(ld_busy), 32'h0);
    chk("load_done", 32'(ld_done), 32'h1);
    chk("load_ovf", 32'(ld_overflow), 32'h0);
    step();
    chk("done_pulse", 32'(ld_done), 32'h0);

    // Stray loader bytes in IDLE are ignored
    send_byte(8'hFF, 1'b1);
    chk("idle_byte_busy", 32'(ld_busy), 32'h0);
    chk("idle_byte_done", 32'(ld_done), 32'h0);

    fetch(32'h0);
    chk("f0_inst", inst, 32'h00100E40);
    chk("f0_valid", 32'(inst_valid), 32'h1);
    chk("f0_err", 32'(addr_err), 32'h0);
    fetch(32'h4);
    chk("f4_inst", inst, 32'h28003826);
    chk("f4_valid", 32'(inst_valid), 32'h1);

    // Stall freezes outputs while addr and fetch_en move
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'(i * 8 + 2);
      fetch_en = (i != 1);
      step();
      chk("stall_inst", inst, 32'h28003826);
      chk("stall_valid", 32'(inst_valid), 32'h1);
      chk("stall_err", 32'(addr_err), 32'h0);
    end
    stall = 1'b0;

    fetch(32'h6);
    chk("mis_inst", inst, 32'h0);
    chk("mis_valid", 32'(inst_valid), 32'h1);
    chk("mis_err", 32'(addr_err), 32'h1);
    fetch(32'h100);
    chk("oor_inst", inst, 32'h0);
    chk("oor_err", 32'(addr_err), 32'h1);
    fetch(32'h8000_0000);
    chk("msb_err", 32'(addr_err), 32'h1);
    fetch(32'h0);
    chk("err_clear", 32'(addr_err), 32'h0);
    fetch_en = 1'b0; step();
    chk("nofetch_inst", inst, 32'h0);
    chk("nofetch_valid", 32'(inst_valid), 32'h0);

    // Overflow load: 65 words, fetch requested throughout, stray ld_start mid-load
    fetch_en = 1'b1; addr = 32'h0;
    ld_start = 1'b1; step(); ld_start = 1'b0;
    chk("start_refuse_valid", 32'(inst_valid), 32'h0);
    chk("start_refuse_inst", inst, 32'h0);
    for (int w = 0; w < 65; w++) begin
      word = 32'hA500_0000 | 32'(w);
      for (int b = 0; b < 4; b++) begin
        ld_start = (w == 10 && b == 2);
        send_byte(word[8*b +: 8], w == 64 && b == 3);
        ld_start = 1'b0;
      end
      if (w == 63) begin
        chk("load_refuse_valid", 32'(inst_valid), 32'h0);
        chk("full_no_ovf", 32'(ld_overflow), 32'h0);
        chk("full_busy", 32'(ld_busy), 32'h1);
      end
    end
    chk("ovf_set", 32'(ld_overflow), 32'h1);
    chk("ovf_idle", 32'(ld_busy), 32'h0);
    chk("ovf_done", 32'(ld_done), 32'h1);
    fetch(32'h0);
    chk("ovf_w0", inst, 32'hA5000000);
    fetch(32'h4);
    chk("ovf_w1", inst, 32'hA5000001);
    fetch(32'hFC);
    chk("ovf_w63", inst, 32'hA500003F);

    // Partial final word is zero-filled; ld_start clears overflow
    fetch_en = 1'b0;
    ld_start = 1'b1; step(); ld_start = 1'b0;
    chk("ovf_cleared", 32'(ld_overflow), 32'h0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    fetch(32'h0);
    chk("partial_w0", inst, 32'h00332211);

    // Reset mid-load with held fetch outputs
    fetch(32'h4);
    chk("pre_rst_inst", inst, 32'hA5000001);
    stall = 1'b1;
    ld_start = 1'b1; step(); ld_start = 1'b0;
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    chk("pre_rst_busy", 32'(ld_busy), 32'h1);
    chk("pre_rst_valid", 32'(inst_valid), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_inst", inst, 32'h0);
    chk("arst_valid", 32'(inst_valid), 32'h0);
    chk("arst_busy", 32'(ld_busy), 32'h0);
    chk("arst_ovf", 32'(ld_overflow), 32'h0);
    step();
    rst_n = 1'b1; stall = 1'b0;
    fetch(32'h0);
    chk("post_rst_w0", inst, 32'h00332211);
    fetch(32'h4);
    chk("post_rst_w1", inst, 32'hA5000001);
    chk("post_rst_valid", 32'(inst_valid), 32'h1);

`ifdef INST_MEM_PARITY_EN
    chk("par_clean", 32'(parity_err), 32'h0);
    dut.mem[1] = dut.mem[1] ^ 32'h0000_0100;
    fetch(32'h4);
    chk("par_err", 32'(parity_err), 32'h1);
    chk("par_inst", inst, 32'h0);
    chk("par_valid", 32'(inst_valid), 32'h1);
`endif

    fetch_en = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
